scoreboard_hazard_ctrlr: RTL and testbench

Parametrised successor to the fixed 5-stage hazard/bypass controller. It holds a per-register latency scoreboard, so producers of different latencies (ALU, load, multi-cycle mul) share one hazard check. At decode/issue it decides stall, issue fire and a bypass tap select per source. It sits between decode and the operand-select muxes of the execute stage.

---
 rtl/scoreboard_hazard_ctrlr.sv | 107 ++++++++++
 tb/tb_scoreboard_hazard_ctrlr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_hazard_ctrlr.sv
// Per-register latency scoreboard: decides stall, issue fire and bypass tap selects at decode.
// Optional macro HAZ_PERF_CNT_EN adds a saturating 32-bit stall-cycle counter output.
module scoreboard_hazard_ctrlr #(
   parameter int  AW         = 5,
   parameter int  MAX_LAT    = 4,
   parameter int  FWD_WINDOW = 1,
   localparam int LW         = $clog2(MAX_LAT + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          w_issue_valid,
   input  logic          w_flush,
   input  logic [AW-1:0] w_rs_addr,
   input  logic          w_rs_used,
   input  logic [AW-1:0] w_rt_addr,
   input  logic          w_rt_used,
   input  logic          w_rt_late,
   input  logic [AW-1:0] w_dst_addr,
   input  logic          w_dst_we,
   input  logic [LW-1:0] w_dst_lat,
   output logic          w_stall,
   output logic          w_issue_fire,
   output logic [LW-1:0] w_rs_fwd_sel,
   output logic [LW-1:0] w_rt_fwd_sel,
`ifdef HAZ_PERF_CNT_EN
   output logic          w_busy,
   output logic [31:0]   w_stall_cycles
`else
   output logic          w_busy
`endif
);
   localparam int            NREGS   = 2 ** AW;
   localparam logic [LW-1:0] FWD     = LW'(FWD_WINDOW);
   localparam logic [LW-1:0] LAT_MAX = LW'(MAX_LAT);

   logic [LW-1:0] cnt_reg  [1:NREGS-1];
   logic [LW-1:0] cnt_view [NREGS];
   logic [LW-1:0] rs_cnt, rt_cnt, dst_cnt, lat_eff, rt_limit;
   logic          active, rs_nz, rt_nz, dst_nz;
   logic          rs_haz, rt_haz, waw_haz, stall, fire, busy;

   // Register 0 is hard-wired: it never has a pending producer.
   always_comb begin
      cnt_view[0] = '0;
      busy        = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         cnt_view[i] = cnt_reg[i];
         busy        = busy | (cnt_reg[i] != '0);
      end
   end

   always_comb begin
      if (w_dst_lat == '0)
         lat_eff = LW'(1);
      else if (w_dst_lat > LAT_MAX)
         lat_eff = LAT_MAX;
      else
         lat_eff = w_dst_lat;
   end

   assign rs_cnt   = cnt_view[w_rs_addr];
   assign rt_cnt   = cnt_view[w_rt_addr];
   assign dst_cnt  = cnt_view[w_dst_addr];
   assign rs_nz    = (w_rs_addr != '0);
   assign rt_nz    = (w_rt_addr != '0);
   assign dst_nz   = (w_dst_addr != '0);
   assign active   = w_issue_valid & ~w_flush;
   // A late-read store operand tolerates one more cycle of producer latency.
   assign rt_limit = FWD + LW'(w_rt_late);

   assign rs_haz  = active & w_rs_used & rs_nz  & (rs_cnt > FWD);
   assign rt_haz  = active & w_rt_used & rt_nz  & (rt_cnt > rt_limit);
   assign waw_haz = active & w_dst_we  & dst_nz & (dst_cnt > lat_eff);
   assign stall   = rs_haz | rt_haz | waw_haz;
   assign fire    = active & ~stall;

   assign w_stall      = stall;
   assign w_issue_fire = fire;
   assign w_rs_fwd_sel = (w_rs_used && rs_nz && !stall) ? rs_cnt : '0;
   assign w_rt_fwd_sel = (w_rt_used && rt_nz && !stall) ? rt_cnt : '0;
   assign w_busy       = busy;

   for (genvar gi = 1; gi < NREGS; gi++) begin : g_cnt
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)
            cnt_reg[gi] <= '0;
         else if (fire && w_dst_we && (w_dst_addr == AW'(gi)))
            cnt_reg[gi] <= lat_eff;
         else if (cnt_reg[gi] != '0)
            cnt_reg[gi] <= cnt_reg[gi] - LW'(1);
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_cycles_reg <= '0;
      else if (stall && (stall_cycles_reg != 32'hFFFF_FFFF))
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
   end

   assign w_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_scoreboard_hazard_ctrlr.sv
// Directed plus randomized bench for scoreboard_hazard_ctrlr against a per-register latency model.
module tb_scoreboard_hazard_ctrlr;
   localparam int AW      = 5;
   localparam int MAX_LAT = 4;
   localparam int FWD     = 1;
   localparam int LW      = $clog2(MAX_LAT + 1);
   localparam int NREGS   = 2 ** AW;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          w_issue_valid, w_flush, w_rs_used, w_rt_used, w_rt_late, w_dst_we;
   logic [AW-1:0] w_rs_addr, w_rt_addr, w_dst_addr;
   logic [LW-1:0] w_dst_lat;
   logic          w_stall, w_issue_fire, w_busy;
   logic [LW-1:0] w_rs_fwd_sel, w_rt_fwd_sel;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0]   w_stall_cycles;
`endif

   scoreboard_hazard_ctrlr dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .w_issue_valid (w_issue_valid),
      .w_flush       (w_flush),
      .w_rs_addr     (w_rs_addr),
      .w_rs_used     (w_rs_used),
      .w_rt_addr     (w_rt_addr),
      .w_rt_used     (w_rt_used),
      .w_rt_late     (w_rt_late),
      .w_dst_addr    (w_dst_addr),
      .w_dst_we      (w_dst_we),
      .w_dst_lat     (w_dst_lat),
      .w_stall       (w_stall),
      .w_issue_fire  (w_issue_fire),
      .w_rs_fwd_sel  (w_rs_fwd_sel),
      .w_rt_fwd_sel  (w_rt_fwd_sel),
`ifdef HAZ_PERF_CNT_EN
      .w_busy        (w_busy),
      .w_stall_cycles(w_stall_cycles)
`else
      .w_busy        (w_busy)
`endif
   );

   always #5 clock = ~clock;

   // Model: remaining cycles until each register's pending result lands.
   int pending [NREGS];
   int perf_model;
   int vecs;
   int miscompares;
   int e_stall, e_fire, e_rs, e_rt, e_lat;
   int stall_run;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input bit f, input int rs, input bit ru, input int rt,
                        input bit tu, input bit tl, input int d, input bit we, input int lat);
      w_issue_valid = v;
      w_flush       = f;
      w_rs_addr     = AW'(rs);
      w_rs_used     = ru;
      w_rt_addr     = AW'(rt);
      w_rt_used     = tu;
      w_rt_late     = tl;
      w_dst_addr    = AW'(d);
      w_dst_we      = we;
      w_dst_lat     = LW'(lat);
   endtask

   // Derive expected outputs from the hazard rules, then compare.
   task automatic check_now(input string tag);
      int  rs, rt, d, lat, busy;
      bit  act, haz;
      rs  = int'(w_rs_addr);
      rt  = int'(w_rt_addr);
      d   = int'(w_dst_addr);
      lat = int'(w_dst_lat);
      e_lat = (lat == 0) ? 1 : ((lat > MAX_LAT) ? MAX_LAT : lat);
      act = w_issue_valid && !w_flush;
      haz = 1'b0;
      if (act && w_rs_used && rs != 0 && pending[rs] > FWD) haz = 1'b1;
      if (act && w_rt_used && rt != 0 && pending[rt] > FWD + int'(w_rt_late)) haz = 1'b1;
      if (act && w_dst_we && d != 0 && pending[d] > e_lat) haz = 1'b1;
      e_stall = haz ? 1 : 0;
      e_fire  = (act && !haz) ? 1 : 0;
      e_rs    = (w_rs_used && rs != 0 && !haz) ? pending[rs] : 0;
      e_rt    = (w_rt_used && rt != 0 && !haz) ? pending[rt] : 0;
      busy = 0;
      foreach (pending[i]) if (pending[i] != 0) busy = 1;
      chk({tag, ".stall"}, 32'(w_stall), 32'(e_stall));
      chk({tag, ".fire"},  32'(w_issue_fire), 32'(e_fire));
      chk({tag, ".rs_sel"}, 32'(w_rs_fwd_sel), 32'(e_rs));
      chk({tag, ".rt_sel"}, 32'(w_rt_fwd_sel), 32'(e_rt));
      chk({tag, ".busy"},  32'(w_busy), 32'(busy));
`ifdef HAZ_PERF_CNT_EN
      chk({tag, ".perf"},  w_stall_cycles, 32'(perf_model));
`endif
   endtask

   task automatic advance();
      int d;
      d = int'(w_dst_addr);
      @(posedge clock);
      for (int r = 1; r < NREGS; r++) begin
         if (e_fire == 1 && w_dst_we && d == r) pending[r] = e_lat;
         else if (pending[r] > 0) pending[r] = pending[r] - 1;
      end
      if (e_stall == 1) perf_model++;
      @(negedge clock);
   endtask

   task automatic step(input string tag);
      #1;
      check_now(tag);
      advance();
   endtask

   initial begin
      vecs = 0;
      miscompares = 0;
      perf_model = 0;
      foreach (pending[i]) pending[i] = 0;
      drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      @(negedge clock);
      #1;
      check_now("reset");
      @(negedge clock);
      reset_n = 1'b1;

      drive(1'b1, 1'b0, 3, 1'b1, 4, 1'b1, 1'b0, 0, 1'b0, 0);
      step("idle_issue");

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 5, 1'b1, 1);
      step("alu_prod");
      drive(1'b1, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      step("alu_cons1");
      step("alu_cons2");

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 7, 1'b1, 2);
      step("load_prod");
      drive(1'b1, 1'b0, 7, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      step("load_stall");
      step("load_fire");
`ifdef HAZ_PERF_CNT_EN
      chk("perf_after_load", w_stall_cycles, 32'd1);
`endif

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 7, 1'b1, 2);
      step("store_prod");
      drive(1'b1, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 0, 1'b0, 0);
      step("store_late");

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 9, 1'b1, 4);
      step("waw_prod");
      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 9, 1'b1, 1);
      stall_run = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (w_stall !== 1'b1) break;
         stall_run++;
         check_now("waw_wait");
         advance();
      end
      step("waw_fire");
      chk("waw_cnt9_is1", 32'(pending[9]), 32'd1);

      drive(1'b1, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b1, 3);
      step("reg0");

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 11, 1'b1, 4);
      step("flush_prod");
      drive(1'b1, 1'b1, 11, 1'b1, 0, 1'b0, 1'b0, 12, 1'b1, 2);
      step("flush_haz");
      drive(1'b1, 1'b0, 12, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 0);
      step("flush_nowrite");

      drive(1'b1, 1'b0, 1, 1'b0, 2, 1'b0, 1'b0, 6, 1'b1, 3);
      step("rst_prod");
      chk("rst_cnt6", 32'(pending[6]), 32'd3);
      drive(1'b1, 1'b0, 6, 1'b1, 6, 1'b1, 1'b0, 0, 1'b0, 0);
      #2;
      reset_n = 1'b0;
      foreach (pending[i]) pending[i] = 0;
      perf_model = 0;
      #1;
      check_now("async_rst");
      @(negedge clock);
      reset_n = 1'b1;

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 7), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 7));
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
